// File: rtl/gray_frame_sequencer.sv
// Frame-level sequencer for raw-to-gray conversion: tracks completed raw banks, streams
// one bank at a time through the converter and hands the finished gray frame to recognition.
module gray_frame_sequencer #(
    parameter int FRAME_LEN = 640*480,
    parameter int ADDR_W    = 19,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              raw_frame_done,
    input  logic              gray_consumed,
    output logic              raw_rd_en,
    output logic [ADDR_W-1:0] raw_rd_addr,
    output logic              raw_rd_bank,
    output logic              gray_wr_en,
    output logic [ADDR_W-1:0] gray_wr_addr,
    output logic              gray_frame_ready,
    output logic              frame_done,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [2:0]        LAST_DRAIN = 3'(RD_LAT - 1);

    state_t            state_reg;
    logic              rd_en_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              rd_bank_reg;
    logic [2:0]        drain_cnt_reg;
    logic              frame_done_reg;
    logic              gray_full_reg;
    logic              overrun_reg;
    logic [1:0]        pending_reg;
    logic [1:0]        pending_dec;
    logic [1:0]        pending_next;
    logic              drop_next;

    logic              en_pipe_reg   [RD_LAT];
    logic [ADDR_W-1:0] addr_pipe_reg [RD_LAT];

    // The DONE decrement is applied before judging whether a new bank still fits.
    always_comb begin
        pending_dec  = (state_reg == DONE) ? pending_reg - 2'd1 : pending_reg;
        drop_next    = raw_frame_done && (pending_dec == 2'd2);
        pending_next = pending_dec;
        if (raw_frame_done && !drop_next) begin
            pending_next = pending_dec + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg   <= 2'd0;
            overrun_reg   <= 1'b0;
            gray_full_reg <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (drop_next) begin
                overrun_reg <= 1'b1;
            end
            if (state_reg == DONE) begin
                gray_full_reg <= 1'b1;
            end else if (gray_consumed) begin
                gray_full_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            rd_en_reg      <= 1'b0;
            rd_addr_reg    <= '0;
            rd_bank_reg    <= 1'b0;
            drain_cnt_reg  <= 3'd0;
            frame_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    frame_done_reg <= 1'b0;
                    if (pending_reg != 2'd0 && !gray_full_reg) begin
                        state_reg   <= RUN;
                        rd_en_reg   <= 1'b1;
                        rd_addr_reg <= '0;
                    end
                end
                RUN: begin
                    if (rd_addr_reg == LAST_ADDR) begin
                        state_reg     <= DRAIN;
                        rd_en_reg     <= 1'b0;
                        drain_cnt_reg <= 3'd0;
                    end else begin
                        rd_addr_reg <= rd_addr_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    // Hold off completion until the last read has come back and been written.
                    if (drain_cnt_reg == LAST_DRAIN) begin
                        state_reg      <= DONE;
                        frame_done_reg <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 3'd1;
                    end
                end
                DONE: begin
                    state_reg      <= IDLE;
                    frame_done_reg <= 1'b0;
                    rd_bank_reg    <= ~rd_bank_reg;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Write strobe/address trail the read side by exactly the raw RAM read latency.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_wr_pipe
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) begin
                        en_pipe_reg[gi]   <= 1'b0;
                        addr_pipe_reg[gi] <= '0;
                    end else begin
                        en_pipe_reg[gi]   <= rd_en_reg;
                        addr_pipe_reg[gi] <= rd_addr_reg;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) begin
                        en_pipe_reg[gi]   <= 1'b0;
                        addr_pipe_reg[gi] <= '0;
                    end else begin
                        en_pipe_reg[gi]   <= en_pipe_reg[gi-1];
                        addr_pipe_reg[gi] <= addr_pipe_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign raw_rd_en        = rd_en_reg;
    assign raw_rd_addr      = rd_addr_reg;
    assign raw_rd_bank      = rd_bank_reg;
    assign gray_wr_en       = en_pipe_reg[RD_LAT-1];
    assign gray_wr_addr     = addr_pipe_reg[RD_LAT-1];
    assign gray_frame_ready = gray_full_reg;
    assign frame_done       = frame_done_reg;
    assign overrun          = overrun_reg;
    assign busy             = (state_reg == RUN) || (state_reg == DRAIN);

endmodule

// File: tb/tb_gray_frame_sequencer.sv
// Bench for gray_frame_sequencer: two instances (read latency 1 and 3) share stimulus and are
// checked every cycle against a frame-position model, plus literal spot checks.
module tb_gray_frame_sequencer;

    localparam int FL = 16;
    localparam int AW = 5;
    localparam int NW = 7 + 2*AW;

    logic clk = 1'b0;
    logic reset;
    logic rfd;
    logic gc;

    logic          rd_en   [2];
    logic [AW-1:0] rd_addr [2];
    logic          rd_bank [2];
    logic          wr_en   [2];
    logic [AW-1:0] wr_addr [2];
    logic          ready   [2];
    logic          fdone   [2];
    logic          busy    [2];
    logic          ovr     [2];

    always #5 clk = ~clk;

    gray_frame_sequencer #(.FRAME_LEN(FL), .ADDR_W(AW), .RD_LAT(1)) dut0 (
        .clk(clk), .reset(reset), .raw_frame_done(rfd), .gray_consumed(gc),
        .raw_rd_en(rd_en[0]), .raw_rd_addr(rd_addr[0]), .raw_rd_bank(rd_bank[0]),
        .gray_wr_en(wr_en[0]), .gray_wr_addr(wr_addr[0]), .gray_frame_ready(ready[0]),
        .frame_done(fdone[0]), .busy(busy[0]), .overrun(ovr[0])
    );

    gray_frame_sequencer #(.FRAME_LEN(FL), .ADDR_W(AW), .RD_LAT(3)) dut1 (
        .clk(clk), .reset(reset), .raw_frame_done(rfd), .gray_consumed(gc),
        .raw_rd_en(rd_en[1]), .raw_rd_addr(rd_addr[1]), .raw_rd_bank(rd_bank[1]),
        .gray_wr_en(wr_en[1]), .gray_wr_addr(wr_addr[1]), .gray_frame_ready(ready[1]),
        .frame_done(fdone[1]), .busy(busy[1]), .overrun(ovr[1])
    );

    // Model: pos = cycles since the first read of the current frame, -1 when not converting.
    int lat [2] = '{1, 3};
    int pos [2];
    int pend [2];
    bit gfull [2];
    bit movr [2];
    bit mbank [2];
    bit model_valid = 1'b0;
    int cyc = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                pos[k] = -1; pend[k] = 0; gfull[k] = 0; movr[k] = 0; mbank[k] = 0;
            end else begin
                bit done_now, start;
                int pn;
                done_now = (pos[k] == FL + lat[k]);
                start    = (pos[k] == -1) && (pend[k] != 0) && !gfull[k];
                pn = pend[k] - (done_now ? 1 : 0);
                if (rfd) begin
                    if (pn == 2) movr[k] = 1;
                    else pn = pn + 1;
                end
                pend[k] = pn;
                if (done_now) gfull[k] = 1;
                else if (gc) gfull[k] = 0;
                if (done_now) mbank[k] = ~mbank[k];
                if (start) pos[k] = 0;
                else if (pos[k] >= 0) pos[k] = done_now ? -1 : pos[k] + 1;
            end
        end
        if (reset) model_valid = 1'b1;
    end

    function automatic logic [NW-1:0] expect_vec(input int k);
        bit e_rd, e_wr, e_fd, e_busy;
        logic [AW-1:0] e_ra, e_wa;
        e_rd   = (pos[k] >= 0) && (pos[k] < FL);
        e_wr   = (pos[k] >= lat[k]) && (pos[k] < FL + lat[k]);
        e_fd   = (pos[k] == FL + lat[k]);
        e_busy = (pos[k] >= 0) && (pos[k] < FL + lat[k]);
        e_ra   = e_rd ? AW'(pos[k]) : '0;
        e_wa   = e_wr ? AW'(pos[k] - lat[k]) : '0;
        return {e_rd, mbank[k], e_wr, gfull[k], e_fd, e_busy, movr[k], e_ra, e_wa};
    endfunction

    function automatic logic [NW-1:0] actual_vec(input int k);
        logic [AW-1:0] a_ra, a_wa;
        a_ra = rd_en[k] ? rd_addr[k] : '0;
        a_wa = wr_en[k] ? wr_addr[k] : '0;
        return {rd_en[k], rd_bank[k], wr_en[k], ready[k], fdone[k], busy[k], ovr[k], a_ra, a_wa};
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (model_valid) begin
                for (int k = 0; k < 2; k++) begin
                    logic [NW-1:0] a, e;
                    a = actual_vec(k);
                    e = expect_vec(k);
                    n_cmp++;
                    if (a !== e) begin
                        n_bad++;
                        $display("FAIL cycle_model cyc=%0d inst=%0d got {rd_en,bank,wr_en,ready,fdone,busy,ovr,ra,wa}=%b required %b",
                                 cyc, k, a, e);
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got %0d required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_reset_state(input string name);
        for (int k = 0; k < 2; k++) begin
            logic [NW-1:0] a;
            a = {rd_en[k], rd_bank[k], wr_en[k], ready[k], fdone[k], busy[k], ovr[k], rd_addr[k], wr_addr[k]};
            n_cmp++;
            if (a !== '0) begin
                n_bad++;
                $display("FAIL %s inst=%0d cyc=%0d got %b required all zero", name, k, cyc, a);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rfd();
        rfd = 1'b1; step(1); rfd = 1'b0;
    endtask

    task automatic pulse_gc();
        gc = 1'b1; step(1); gc = 1'b0;
    endtask

    initial begin
        bit found;
        fork
            compare_loop();
        join_none
        reset = 1'b1; rfd = 1'b0; gc = 1'b0;
        step(3);
        check_reset_state("reset_state");
        reset = 1'b0;
        step(2);

        // First frame: pulse in cycle t, reads from t+2, frame_done at t+19 (lat 1) / t+21 (lat 3).
        pulse_rfd();
        check("start_not_yet", int'(rd_en[0]), 0);
        step(1);
        check("first_rd_en", int'(rd_en[0]), 1);
        check("first_rd_addr", int'(rd_addr[0]), 0);
        check("first_bank", int'(rd_bank[0]), 0);
        check("first_rd_en_lat3", int'(rd_en[1]), 1);
        step(1);
        check("first_wr_en", int'(wr_en[0]), 1);
        check("first_wr_addr", int'(wr_addr[0]), 0);
        step(15);
        check("last_wr_addr", int'(wr_addr[0]), 15);
        check("drain_rd_en", int'(rd_en[0]), 0);
        step(1);
        check("frame_done_t19", int'(fdone[0]), 1);
        step(2);
        check("frame_done_lat3_t21", int'(fdone[1]), 1);
        check("ready_after_frame", int'(ready[0]), 1);
        step(3);

        // Buffer full: a new bank must wait for the acknowledge.
        pulse_rfd();
        step(5);
        check("held_while_full", int'(busy[0]), 0);
        pulse_gc();
        step(1);
        check("restart_after_consume", int'(rd_en[0]), 1);
        check("second_bank", int'(rd_bank[0]), 1);
        step(25);

        // Three completions with the buffer full: the third is dropped.
        pulse_rfd(); step(1);
        pulse_rfd(); step(1);
        pulse_rfd(); step(1);
        check("overrun_lat1", int'(ovr[0]), 1);
        check("overrun_lat3", int'(ovr[1]), 1);

        // New completion landing in the DONE cycle while two banks are pending.
        reset = 1'b1; step(1); reset = 1'b0;
        pulse_rfd(); step(1);
        pulse_rfd();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (fdone[0]) found = 1'b1;
            else step(1);
        end
        check("done_seen", int'(found), 1);
        pulse_rfd();
        check("no_overrun_on_done", int'(ovr[0]), 0);
        pulse_gc(); step(25);
        pulse_gc(); step(25);
        pulse_gc(); step(5);

        // Reset in the middle of a frame.
        reset = 1'b1; step(1); reset = 1'b0; step(2);
        pulse_rfd();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (rd_en[0] && rd_addr[0] == AW'(7)) found = 1'b1;
            else step(1);
        end
        check("addr7_seen", int'(found), 1);
        reset = 1'b1; step(1);
        check_reset_state("midframe_reset");
        reset = 1'b0; step(2);
        pulse_rfd(); step(1);
        check("restart_rd_en", int'(rd_en[0]), 1);
        check("restart_addr", int'(rd_addr[0]), 0);
        check("restart_bank", int'(rd_bank[0]), 0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rfd   = ($urandom_range(0, 19) == 0);
            gc    = ready[0] ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 699) == 0);
            step(1);
        end
        rfd = 1'b0; gc = 1'b0; reset = 1'b0;
        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gray_frame_sequencer.md
# gray_frame_sequencer

Sequences raw-to-grayscale conversion of whole camera frames between the capture stage and the recognition stage. The capture stage fills two raw-frame banks alternately; this block tracks completed banks and waits until the single gray frame buffer is free. It then streams every pixel of the oldest completed bank through the raw→gray datapath, generating read and write addresses and enables with the RAM read latency compensated. Downstream recognition is notified per finished gray frame, and the buffer is released by its acknowledge.

## Interface
- FRAME_LEN, 640*480, pixels per frame
- ADDR_W, 19, address width; must satisfy 2**ADDR_W >= FRAME_LEN
- RD_LAT, 1, raw RAM read latency in cycles (1..4)

- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- raw_frame_done  in  1  one-cycle pulse: capture finished a raw bank
- gray_consumed  in  1  one-cycle pulse: recognition finished with gray buffer
- raw_rd_en  out  1  raw RAM read strobe
- raw_rd_addr  out  ADDR_W  raw pixel address within bank
- raw_rd_bank  out  1  raw bank being converted
- gray_wr_en  out  1  gray RAM write strobe, aligned with returned raw data
- gray_wr_addr  out  ADDR_W  gray pixel address
- gray_frame_ready  out  1  level: gray buffer holds an unconsumed frame
- frame_done  out  1  one-cycle pulse at end of each converted frame
- busy  out  1  high in RUN or DRAIN
- overrun  out  1  sticky: a raw frame was dropped

## Operation
- pending: 2-bit count of completed, unconverted raw banks (0..2).
  - raw_frame_done with pending==2 (after same-cycle decrement): frame dropped, pending unchanged, overrun set; cleared only by reset.
  - Increment and DONE decrement in the same cycle: net unchanged, no overrun.
- gray_full: set in DONE, cleared by gray_consumed. gray_consumed while gray_full==0 is ignored. gray_frame_ready = gray_full.
- FSM states:
  - IDLE: go to RUN when pending!=0 and gray_full==0 (uses registered values, not same-cycle inputs).
  - RUN: raw_rd_en=1; rd_addr counts 0..FRAME_LEN-1, one per cycle, no stalls. After issuing address FRAME_LEN-1, go to DRAIN.
  - DRAIN: raw_rd_en=0 for RD_LAT cycles so the final writes complete; then go to DONE.
  - DONE: single cycle. frame_done=1, gray_full<=1, pending decrements, raw_rd_bank toggles; next state IDLE.
- Write path: gray_wr_en and gray_wr_addr are raw_rd_en and raw_rd_addr delayed by exactly RD_LAT cycles through a shift register. The external raw_grayscale converter sits combinationally between RAM output and gray RAM input.
- raw_rd_bank is stable for a whole frame; it starts at 0 and follows capture bank order.
- Reset mid-frame: abandons conversion immediately, clears the delay pipe (no stray writes), and returns all state to reset values.

## Timing
- Reset values: state IDLE, pending 0, gray_full 0, overrun 0, raw_rd_bank 0, all address counters 0, all enables/pulses 0, busy 0.
- Start latency: first raw_rd_en is 1 cycle after the IDLE start condition is registered. raw_frame_done at cycle t with an empty buffer gives raw_rd_en at t+2.
- Frame length: RUN FRAME_LEN cycles + DRAIN RD_LAT + DONE 1. IDLE→IDLE total FRAME_LEN+RD_LAT+2 cycles.
- gray_wr_en high for exactly FRAME_LEN cycles per frame; the last write occurs in the final DRAIN cycle.
- Back-to-back frames: with pending!=0 and gray_consumed arriving in or before DONE, the next RUN starts 2 cycles after DONE (the IDLE cycle that evaluates the condition).
- busy = RUN or DRAIN. Outputs are registered except busy and gray_frame_ready, which decode state and flops.

## Test plan
- FRAME_LEN=16, RD_LAT=1, one raw_frame_done → addresses 0..15 on bank 0. Writes 0..15 each one cycle later. frame_done at cycle 19 after the pulse. gray_frame_ready=1, pending=0.
- Second raw_frame_done while gray_full=1 → stays IDLE. Assert gray_consumed → RUN starts 2 cycles later on bank 1.
- Three raw_frame_done pulses with no gray_consumed → pending=2, overrun=1 after the third pulse. Exactly one frame converted.
- raw_frame_done in the same cycle as DONE with pending=2 → pending stays 2, overrun stays 0.
- RD_LAT=3: the gray_wr_addr sequence equals the raw_rd_addr sequence shifted 3 cycles. DRAIN lasts 3 cycles; 16 writes total.
- Reset asserted at rd_addr=7 → the next cycle shows all outputs at reset values and no gray_wr_en. A fresh raw_frame_done restarts conversion at address 0, bank 0.
